// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and default width for the bit-serial adder
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational one-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell over two WIDTH-bit operands, LSB first
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CNT_W-1:0] cnt;
  logic carry, s, c, accept, last;
  fa_cell u_fa (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .cin(carry),
    .s(s),
    .cout(c)
  );
  always_comb begin
    accept = start && (state == ST_IDLE || state == ST_DONE);
    last = cnt == CNT_W'(WIDTH - 1);
    state_n = state == ST_RUN ? (last ? ST_DONE : ST_RUN) : (accept ? ST_RUN : ST_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == ST_RUN;
      done <= state_n == ST_DONE;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        carry <= cin;
        cnt <= '0;
        sum <= '0;
        cout <= 1'b0;
      end else if (state == ST_RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        carry <= c;
        sum <= {s, sum[WIDTH-1:1]};
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) cout <= c;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomised checks of serial_add_ctrl at WIDTH=8 and WIDTH=16
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy8, done8, cout8, busy16, done16, cout16;
  logic [7:0] sum8;
  logic [15:0] sum16;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  // called at a negedge; returns at the negedge after the accept edge
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic c);
    start = 1'b1;
    a = av;
    b = bv;
    cin = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // samples the current negedge and the following ones, cycles samples in total
  task automatic watch8(input int cycles, output int first_done, output int busy_cnt, output int done_cnt);
    first_done = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 1; i <= cycles; i++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
      end
      if (i < cycles) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0)
      begin failures++; $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8); end
    checks++;
    if ({busy16, done16, sum16, cout16} !== 19'd0)
      begin failures++; $display("FAIL reset16: got busy=%b done=%b sum=%h cout=%b, want all 0", busy16, done16, sum16, cout16); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00)
      begin failures++; $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8); end
  endtask

  task automatic test_basic;
    int fd, bc, dc;
    launch(16'h005A, 16'h003C, 1'b0);
    watch8(9, fd, bc, dc);
    checks++;
    if (fd !== 9 || dc !== 1) begin failures++; $display("FAIL basic_latency: got done at %0d (%0d pulses), want 9 (1)", fd, dc); end
    checks++;
    if (bc !== 8) begin failures++; $display("FAIL basic_busy: got %0d busy cycles, want 8", bc); end
    checks++;
    if ({cout8, sum8} !== 9'h096) begin failures++; $display("FAIL basic_result: got cout=%b sum=%h, want 0 96", cout8, sum8); end
    repeat (3) @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== 9'h096)
      begin failures++; $display("FAIL basic_hold: got done=%b busy=%b cout=%b sum=%h, want 0 0 0 96", done8, busy8, cout8, sum8); end
  endtask

  task automatic test_carry;
    int fd, bc, dc;
    launch(16'h00FF, 16'h0001, 1'b0);
    watch8(9, fd, bc, dc);
    checks++;
    if (fd !== 9 || {cout8, sum8} !== 9'h100)
      begin failures++; $display("FAIL carry_ff_01: got done at %0d cout=%b sum=%h, want 9 1 00", fd, cout8, sum8); end
    launch(16'h00FF, 16'h00FF, 1'b1);
    watch8(9, fd, bc, dc);
    checks++;
    if (fd !== 9 || {cout8, sum8} !== 9'h1FF)
      begin failures++; $display("FAIL carry_ff_ff_1: got done at %0d cout=%b sum=%h, want 9 1 ff", fd, cout8, sum8); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int fd, bc, dc;
    launch(16'h000F, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 16'h0011;
    b = 16'h0022;
    @(negedge clk);
    start = 1'b0;
    watch8(11, fd, bc, dc);
    checks++;
    if (fd !== 6 || dc !== 1)
      begin failures++; $display("FAIL ignore_done: got first done idx %0d pulses %0d, want 6 1", fd, dc); end
    checks++;
    if ({cout8, sum8} !== 9'h010)
      begin failures++; $display("FAIL ignore_result: got cout=%b sum=%h, want 0 10", cout8, sum8); end
  endtask

  task automatic test_back_to_back;
    int fd, bc, dc;
    launch(16'h0012, 16'h0034, 1'b0);
    watch8(8, fd, bc, dc);
    start = 1'b1;
    a = 16'h0080;
    b = 16'h0080;
    cin = 1'b0;
    @(negedge clk);
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || {cout8, sum8} !== 9'h046)
      begin failures++; $display("FAIL b2b_first: got done=%b busy=%b cout=%b sum=%h, want 1 0 0 46", done8, busy8, cout8, sum8); end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0)
      begin failures++; $display("FAIL b2b_no_idle: got busy=%b done=%b, want 1 0", busy8, done8); end
    start = 1'b0;
    @(negedge clk);
    watch8(8, fd, bc, dc);
    checks++;
    if (fd !== 8 || dc !== 1 || {cout8, sum8} !== 9'h100)
      begin failures++; $display("FAIL b2b_second: got done idx %0d pulses %0d cout=%b sum=%h, want 8 1 1 00", fd, dc, cout8, sum8); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int fd, bc, dc;
    launch(16'h00FF, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0)
      begin failures++; $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8); end
    @(negedge clk);
    rst_n = 1'b1;
    watch8(12, fd, bc, dc);
    checks++;
    if (dc !== 0 || bc !== 0)
      begin failures++; $display("FAIL aborted_op: got %0d done pulses %0d busy cycles, want 0 0", dc, bc); end
    @(negedge clk);
    launch(16'h0033, 16'h0044, 1'b1);
    watch8(9, fd, bc, dc);
    checks++;
    if (fd !== 9 || {cout8, sum8} !== 9'h078)
      begin failures++; $display("FAIL after_reset_op: got done at %0d cout=%b sum=%h, want 9 0 78", fd, cout8, sum8); end
  endtask

  task automatic test_random;
    logic [15:0] av, bv;
    logic c;
    logic [8:0] e8, r8;
    logic [16:0] e16;
    int fd8, fd16, dc8;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      c = 1'($urandom);
      e8 = 9'(av[7:0]) + 9'(bv[7:0]) + 9'(c);
      e16 = 17'(av) + 17'(bv) + 17'(c);
      fd8 = -1;
      fd16 = -1;
      dc8 = 0;
      r8 = '0;
      launch(av, bv, c);
      for (int n = 1; n <= 17; n++) begin
        if (done8) begin
          dc8++;
          if (fd8 < 0) begin fd8 = n; r8 = {cout8, sum8}; end
        end
        if (done16 && fd16 < 0) fd16 = n;
        if (n < 17) @(negedge clk);
      end
      checks++;
      if (fd8 !== 9 || dc8 !== 1)
        begin failures++; $display("FAIL rand8_latency op %0d: got done at %0d (%0d pulses), want 9 (1)", k, fd8, dc8); end
      checks++;
      if (r8 !== e8)
        begin failures++; $display("FAIL rand8_sum op %0d: got %h, want %h (a=%h b=%h cin=%b)", k, r8, e8, av[7:0], bv[7:0], c); end
      checks++;
      if (fd16 !== 17)
        begin failures++; $display("FAIL rand16_latency op %0d: got done at %0d, want 17", k, fd16); end
      checks++;
      if ({cout16, sum16} !== e16)
        begin failures++; $display("FAIL rand16_sum op %0d: got %h, want %h (a=%h b=%h cin=%b)", k, {cout16, sum16}, e16, av, bv, c); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
